regfile_read_arbiter: RTL and testbench

Shares one register-file read port (5-bit select driving the 64-bit-wide tree of 32:1 muxes) among up to four requesters with round-robin arbitration. Each granted read returns registered data one cycle after the grant. Address 31 reads as zero (XZR). Write-port snooping forwards same-cycle writes so that no requester sees stale data. Sits between decode/operand-fetch requesters and the register-file read mux trees.

---
 rtl/regfile_read_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Two overlapped stages: grant (select rd_addr) then data (register rd_data/forwarded write).
module regfile_read_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic                 stall,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic [AW-1:0]        rd_addr,
  input  logic [DW-1:0]        rd_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] XzrAddr = '1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [PW-1:0]   win;
  logic            found;
  logic            fwd_hit;

  // First set req bit at or after ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    logic [PW:0] idx;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  // Grant stage
  always_comb begin
    gnt_d     = '0;
    rd_addr_d = rd_addr_q;
    ptr_d     = ptr_q;
    if (!stall && found) begin
      gnt_d[win] = 1'b1;
      rd_addr_d  = addr[32'(win)*AW +: AW];
      if (32'(win) == NREQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + PW'(1);
      end
    end
  end

  // Same-edge write to the register being read must win over the stale mux output.
  assign fwd_hit = wr_en && (wr_addr == rd_addr_q) && (wr_addr != XzrAddr);

  // Data stage
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (|gnt_q) begin
      rvalid_d = gnt_q;
      if (rd_addr_q == XzrAddr) begin
        rdata_d = '0;
      end else if (fwd_hit) begin
        rdata_d = wr_data;
      end else begin
        rdata_d = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      rd_addr_q <= XzrAddr;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign rd_addr = rd_addr_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign busy    = |gnt_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed + random bench for regfile_read_arbiter with a grant/data scoreboard;
// a second NREQ=3 instance covers pointer wrap on a non-power-of-two requester count.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req;
  logic [19:0] addr;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [63:0] rdata;
  logic        busy;

  logic [2:0]  req3;
  logic [14:0] addr3;
  logic [4:0]  rd_addr3;
  logic [63:0] rd_data3;
  logic [2:0]  gnt3;
  logic [2:0]  rvalid3;
  logic [63:0] rdata3;
  logic        busy3;

  logic [63:0] regs [32];
  assign rd_data  = regs[rd_addr];
  assign rd_data3 = regs[rd_addr3];

  regfile_read_arbiter #(.NREQ(4), .AW(5), .DW(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .addr    (addr),
    .stall   (stall),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .busy    (busy)
  );

  regfile_read_arbiter #(.NREQ(3), .AW(5), .DW(64)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .req     (req3),
    .addr    (addr3),
    .stall   (stall),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr3),
    .rd_data (rd_data3),
    .gnt     (gnt3),
    .rvalid  (rvalid3),
    .rdata   (rdata3),
    .busy    (busy3)
  );

  typedef struct {
    logic [3:0] g;
    logic [4:0] a;
  } rd_t;
  rd_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]  m_ptr;
  logic [3:0]  m_gnt;
  logic [4:0]  m_rdaddr;
  logic [63:0] m_rdata;
  logic [3:0]  m_rvalid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 2'd0;
    m_gnt    = 4'd0;
    m_rdaddr = 5'd31;
    m_rdata  = 64'd0;
    m_rvalid = 4'd0;
    sb.delete();
  endtask

  // Predict one edge from the inputs currently driven, clock it, then compare.
  task automatic cycle();
    rd_t  e;
    logic found;
    int   w;
    if (sb.size() > 0) begin
      e        = sb.pop_front();
      m_rvalid = e.g;
      if (e.a == 5'd31)                    m_rdata = 64'd0;
      else if (wr_en && wr_addr == e.a)    m_rdata = wr_data;
      else                                 m_rdata = regs[e.a];
    end else begin
      m_rvalid = 4'd0;
    end
    m_gnt = 4'd0;
    found = 1'b0;
    if (!stall) begin
      for (int i = 0; i < 4; i++) begin
        w = (int'(m_ptr) + i) % 4;
        if (!found && req[w]) begin
          found    = 1'b1;
          m_gnt    = 4'b0001 << w;
          m_rdaddr = addr[w*5 +: 5];
          sb.push_back('{m_gnt, m_rdaddr});
        end
      end
      if (found) m_ptr = 2'((int'($clog2(m_gnt)) + 1) % 4);
    end
    @(posedge clk);
    #1;
    if (wr_en && wr_addr != 5'd31) regs[wr_addr] = wr_data;
    check("gnt", 64'(gnt), 64'(m_gnt));
    check("rvalid", 64'(rvalid), 64'(m_rvalid));
    check("rdata", rdata, m_rdata);
    check("rd_addr", 64'(rd_addr), 64'(m_rdaddr));
    check("busy", 64'(busy), 64'(|m_gnt));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0001_0001_0001);
    regs[31] = 64'hDEAD;
    reset   = 1'b0;
    req     = 4'b1111;
    addr    = {5'd12, 5'd9, 5'd5, 5'd2};
    stall   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 64'd0;
    req3    = 3'b000;
    addr3   = {5'd20, 5'd21, 5'd22};

    // Reset held with all requests pending
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd31);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt3", 64'(gnt3), 64'd0);
    reset = 1'b1;

    // Round robin, first grant goes to req0
    cycle();
    check("first_gnt", 64'(gnt), 64'h1);
    repeat (4) cycle();
    check("rr_wrap_gnt", 64'(gnt), 64'h1);
    req = 4'b0000;
    cycle();

    // XZR read
    addr[4:0] = 5'd31;
    req = 4'b0001;
    cycle();
    req = 4'b0000;
    cycle();
    check("xzr_rdata", rdata, 64'd0);

    // Forwarding at the data edge
    addr[4:0] = 5'd7;
    req = 4'b0001;
    cycle();
    req     = 4'b0000;
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 64'h1234;
    cycle();
    wr_en = 1'b0;
    check("fwd_rdata", rdata, 64'h1234);

    // Write to 31 is not forwarded
    req = 4'b0001;
    cycle();
    req     = 4'b0000;
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 64'hBEEF;
    cycle();
    wr_en = 1'b0;
    check("nofwd31_rdata", rdata, 64'h1234);

    // Stall for two cycles after a grant
    req = 4'b0101;
    cycle();
    stall = 1'b1;
    cycle();
    check("stall_gnt", 64'(gnt), 64'd0);
    check("stall_rvalid_done", 64'(|rvalid), 64'd1);
    cycle();
    stall = 1'b0;
    repeat (2) cycle();
    req = 4'b0000;
    cycle();

    // Reset while a req2 read is in flight
    req = 4'b0100;
    cycle();
    check("mid_gnt2", 64'(gnt), 64'h4);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req = 4'b0000;
    cycle();
    check("mid_rst_norvalid", 64'(rvalid), 64'd0);
    req = 4'b1111;
    cycle();
    check("mid_rst_ptr0", 64'(gnt), 64'h1);
    req = 4'b0000;
    cycle();

    // NREQ=3 wrap: 100 -> ptr 0 -> 001 -> ptr 1 -> 011 grants 010
    req3 = 3'b100;
    cycle();
    check("n3_gnt_100", 64'(gnt3), 64'h4);
    req3 = 3'b001;
    cycle();
    check("n3_gnt_001", 64'(gnt3), 64'h1);
    check("n3_rvalid_100", 64'(rvalid3), 64'h4);
    req3 = 3'b011;
    cycle();
    check("n3_gnt_010", 64'(gnt3), 64'h2);
    req3 = 3'b000;
    cycle();

    // Random traffic with writes biased toward the register being read
    for (int n = 0; n < 60; n++) begin
      req     = 4'($urandom);
      stall   = ($urandom_range(0, 3) == 0);
      wr_en   = 1'($urandom);
      wr_addr = ($urandom_range(0, 1) == 1) ? m_rdaddr : 5'($urandom_range(0, 31));
      wr_data = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) == 0) addr = 20'($urandom);
      cycle();
    end
    req   = 4'b0000;
    stall = 1'b0;
    wr_en = 1'b0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
